term_char_writer: RTL and testbench
===================================

TERM_CHAR_WRITER -- requirements
Module: term_char_writer

Interface
REQ-001 COLS, 80, characters per text row.
REQ-002 ROWS, 30, text rows on screen; COLS*ROWS SHALL fit in 12 address bits.
REQ-003 sys_clk  in  1  single system clock; all logic rising-edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 key_data  in  8  received character from the SPI deserializer; valid while new_key high.
REQ-006 new_key  in  1  new-character level flag, high for multiple sys_clk cycles per character.
REQ-007 ram_we  out  1  text RAM write strobe, one cycle per character cell write.
REQ-008 ram_addr  out  12  text RAM address = phys_row*COLS + col.
REQ-009 ram_wdata  out  8  character written to the text RAM.
REQ-010 cursor_col  out  7  logical cursor column, 0..COLS-1.
REQ-011 cursor_row  out  5  logical cursor row, 0..ROWS-1.
REQ-012 top_row  out  5  physical RAM row shown as screen line 0, for the display scanner.
REQ-013 busy  out  1  high while a multi-cycle clear is in progress.
REQ-014 overflow  out  1  one-cycle pulse when a character is dropped.

Function
REQ-015 Rising edge of new_key (sampled high after sampled low) SHALL capture key_data into a one-deep pending register; level and falling edge SHALL be ignored.
REQ-016 phys_row SHALL equal (top_row + cursor_row) mod ROWS; wrap computed without a divider.
REQ-017 FSM states: IDLE, EXEC, CLR_LINE, CLR_SCREEN; busy=1 exactly in CLR_LINE and CLR_SCREEN.
REQ-018 IDLE -> EXEC when pending valid; EXEC consumes pending in one cycle and returns to IDLE unless a clear is started.
REQ-019 Printable 0x20..0x7E: ram_we=1 at cursor with ram_wdata=char; col+1; at col=COLS-1 col->0 and a line feed SHALL be performed.
REQ-020 Timing: ram_we for a printable char SHALL assert on the 3rd sys_clk rising edge after the edge on which new_key is first sampled high (edge detect, capture, EXEC).
REQ-021 0x0D (CR): col->0, no write.
REQ-022 0x0A (LF): row<ROWS-1 -> row+1; row=ROWS-1 -> row unchanged, top_row+1 mod ROWS, enter CLR_LINE.
REQ-023 0x08 (BS): col>0 -> col-1 and write 0x20 at new cell; col=0 -> no action, no write.
REQ-024 0x0C (FF): top_row->0, cursor->(0,0), enter CLR_SCREEN.
REQ-025 All other codes (0x00..0x1F not listed, 0x7F..0xFF) SHALL be discarded with no state change.
REQ-026 CLR_LINE: writes 0x20 to all COLS cells of the new bottom physical row, col index 0..COLS-1, one per cycle, then IDLE.
REQ-027 CLR_SCREEN: writes 0x20 to addresses 0..COLS*ROWS-1 in order, one per cycle, then IDLE.
REQ-028 A new edge while busy or while pending full SHALL be stored if pending empty; else the new char is dropped and overflow pulses one cycle.
REQ-029 Pending slot freed the same cycle EXEC consumes it; an edge in that cycle SHALL be accepted, not dropped.
REQ-030 ram_addr/ram_wdata SHALL be registered and stable whenever ram_we=1; don't-care otherwise.

Reset
REQ-031 rst SHALL force state IDLE, ram_we=0, ram_addr=0, ram_wdata=0, cursor (0,0), top_row=0, busy=0, overflow=0, pending empty, edge-detect history=1 (no spurious edge if new_key high at release).
REQ-032 rst during CLR_LINE/CLR_SCREEN SHALL abort the clear immediately; no further writes.
REQ-033 The screen SHALL NOT be cleared by reset; software sends FF.

Structure
REQ-034 Package term_pkg SHALL hold COLS, ROWS, address widths, control codes (CR, LF, BS, FF, SPACE) and the FSM state enum.
REQ-035 Sub-module key_edge_capture (edge detect + pending register + overflow) SHALL be separate; remaining logic in term_char_writer.

Verification
REQ-036 Send 'A'(0x41) at reset cursor -> one ram_we, addr 0, data 0x41, 3 clocks after new_key high; cursor_col=1.
REQ-037 80 x 'x' then 'y' -> 'y' at addr 80, cursor (1,1), no busy.
REQ-038 At row 29, col 5 send LF -> top_row=1, cursor_row=29, busy 80 cycles, writes 0x20 to addr 0..79.
REQ-039 Col 0 BS -> no write; col 3 BS -> write 0x20 at col 2, cursor_col=2.
REQ-040 FF then 'a','b','c' during clear -> 'a' held, 'b','c' dropped with two overflow pulses, 2400 clear writes, then 'a' at addr 0.
REQ-041 rst asserted mid-CLR_SCREEN -> ram_we low next cycle, all outputs at reset values.

Source files
------------

// File: rtl/term_pkg.sv
// Shared geometry, control codes and FSM encoding for the text-terminal writer.
package term_pkg;

    localparam int COLS   = 80;
    localparam int ROWS   = 30;
    localparam int ADDR_W = 12;   // COLS*ROWS = 2400 cells fits in 12 bits
    localparam int COL_W  = 7;
    localparam int ROW_W  = 5;

    localparam logic [COL_W-1:0]  LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [ROW_W:0]    ROWS_X   = ROWS[ROW_W:0];
    localparam logic [ADDR_W-1:0] LINE_N   = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] CELLS_N  = ADDR_W'(COLS * ROWS);

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_CLR_LINE,
        ST_CLR_SCREEN
    } state_t;

    // Modulo-ROWS wrap of a sum of two in-range rows: one conditional subtract.
    function automatic logic [ROW_W-1:0] wrap_row(input logic [ROW_W:0] sum);
        logic [ROW_W:0] diff;
        diff = sum - ROWS_X;
        if (sum >= ROWS_X)
            return diff[ROW_W-1:0];
        else
            return sum[ROW_W-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                    input logic [COL_W-1:0] col);
        return ADDR_W'(row) * LINE_N + ADDR_W'(col);
    endfunction

endpackage

// File: rtl/key_edge_capture.sv
// Rising-edge detect on the new_key level flag plus a one-deep pending slot.
// A character arriving while the slot is occupied (and not being consumed)
// is dropped and flagged with a single-cycle overflow pulse.
module key_edge_capture
    import term_pkg::*;
(
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       new_key,
    input  logic [7:0] key_data,
    input  logic       consume,
    output logic       pend_valid,
    output logic [7:0] pend_data,
    output logic       overflow
);

    logic       key_s;
    logic       key_hist;
    logic [7:0] data_s;
    logic       rise;

    // History resets high so a key already held at reset release is not an edge.
    assign rise = key_s & ~key_hist;

    // Sample the flag, detect the edge, and fill/free the pending slot.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            key_s      <= 1'b1;
            key_hist   <= 1'b1;
            data_s     <= 8'h00;
            pend_valid <= 1'b0;
            pend_data  <= 8'h00;
            overflow   <= 1'b0;
        end else begin
            key_s    <= new_key;
            key_hist <= key_s;
            data_s   <= key_data;
            overflow <= 1'b0;
            if (rise) begin
                if (!pend_valid || consume) begin
                    pend_valid <= 1'b1;
                    pend_data  <= data_s;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (consume) begin
                pend_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/term_char_writer.sv
// Character-to-text-RAM writer with cursor tracking, hardware scrolling
// through top_row, and multi-cycle line / screen clears.
//
//   state         | meaning
//   --------------+------------------------------------------------------
//   ST_IDLE       | waiting for a pending character
//   ST_EXEC       | decode pending char, one RAM write at most, free slot
//   ST_CLR_LINE   | writing spaces across the freshly scrolled-in row
//   ST_CLR_SCREEN | writing spaces to every cell, address 0 upwards
module term_char_writer
    import term_pkg::*;
(
    input  logic        sys_clk,
    input  logic        rst,
    input  logic [7:0]  key_data,
    input  logic        new_key,
    output logic        ram_we,
    output logic [11:0] ram_addr,
    output logic [7:0]  ram_wdata,
    output logic [6:0]  cursor_col,
    output logic [4:0]  cursor_row,
    output logic [4:0]  top_row,
    output logic        busy,
    output logic        overflow
);

    state_t            state, state_n;
    logic              pend_valid;
    logic [7:0]        pend_data;
    logic              consume;
    logic [ROW_W-1:0]  phys_row;
    logic [COL_W-1:0]  col_n;
    logic [ROW_W-1:0]  row_n, top_n;
    logic              we_n;
    logic [ADDR_W-1:0] addr_n;
    logic [7:0]        wdata_n;
    logic [ADDR_W-1:0] clr_addr, clr_addr_n;
    logic [ADDR_W-1:0] clr_left, clr_left_n;
    logic              do_lf;

    key_edge_capture u_cap (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .new_key    (new_key),
        .key_data   (key_data),
        .consume    (consume),
        .pend_valid (pend_valid),
        .pend_data  (pend_data),
        .overflow   (overflow)
    );

    assign phys_row = wrap_row({1'b0, top_row} + {1'b0, cursor_row});
    assign busy     = (state == ST_CLR_LINE) || (state == ST_CLR_SCREEN);

    // Register FSM state, cursor, scroll origin, clear counters and RAM port.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cursor_col <= '0;
            cursor_row <= '0;
            top_row    <= '0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            clr_addr   <= '0;
            clr_left   <= '0;
        end else begin
            state      <= state_n;
            cursor_col <= col_n;
            cursor_row <= row_n;
            top_row    <= top_n;
            ram_we     <= we_n;
            ram_addr   <= addr_n;
            ram_wdata  <= wdata_n;
            clr_addr   <= clr_addr_n;
            clr_left   <= clr_left_n;
        end
    end

    // Next-state decode: character execution, line feed/scroll, clear sweeps.
    always_comb begin
        state_n    = state;
        col_n      = cursor_col;
        row_n      = cursor_row;
        top_n      = top_row;
        we_n       = 1'b0;
        addr_n     = ram_addr;
        wdata_n    = ram_wdata;
        clr_addr_n = clr_addr;
        clr_left_n = clr_left;
        consume    = 1'b0;
        do_lf      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (pend_valid)
                    state_n = ST_EXEC;
            end
            ST_EXEC: begin
                consume = 1'b1;
                state_n = ST_IDLE;
                if (pend_data >= 8'h20 && pend_data <= 8'h7E) begin
                    we_n    = 1'b1;
                    addr_n  = cell_addr(phys_row, cursor_col);
                    wdata_n = pend_data;
                    if (cursor_col == LAST_COL) begin
                        col_n = '0;
                        do_lf = 1'b1;
                    end else begin
                        col_n = cursor_col + 7'd1;
                    end
                end else if (pend_data == CH_CR) begin
                    col_n = '0;
                end else if (pend_data == CH_LF) begin
                    do_lf = 1'b1;
                end else if (pend_data == CH_BS) begin
                    if (cursor_col != '0) begin
                        col_n   = cursor_col - 7'd1;
                        we_n    = 1'b1;
                        addr_n  = cell_addr(phys_row, cursor_col - 7'd1);
                        wdata_n = CH_SPACE;
                    end
                end else if (pend_data == CH_FF) begin
                    top_n      = '0;
                    col_n      = '0;
                    row_n      = '0;
                    clr_addr_n = '0;
                    clr_left_n = CELLS_N;
                    state_n    = ST_CLR_SCREEN;
                end

                // The scrolled-in bottom row lives where the old top row was.
                if (do_lf) begin
                    if (cursor_row != LAST_ROW) begin
                        row_n = cursor_row + 5'd1;
                    end else begin
                        top_n      = wrap_row({1'b0, top_row} + 6'd1);
                        clr_addr_n = cell_addr(top_row, '0);
                        clr_left_n = LINE_N;
                        state_n    = ST_CLR_LINE;
                    end
                end
            end
            ST_CLR_LINE, ST_CLR_SCREEN: begin
                we_n       = 1'b1;
                addr_n     = clr_addr;
                wdata_n    = CH_SPACE;
                clr_addr_n = clr_addr + 12'd1;
                clr_left_n = clr_left - 12'd1;
                if (clr_left == 12'd1)
                    state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_term_char_writer.sv
// Directed bench for term_char_writer: reset, timing, wrap, scroll,
// backspace, form-feed with overflow, and reset during a clear.
module tb_term_char_writer;

    logic        sys_clk;
    logic        rst;
    logic [7:0]  key_data;
    logic        new_key;
    logic        ram_we;
    logic [11:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic [4:0]  top_row;
    logic        busy;
    logic        overflow;

    int tests_run;
    int tests_failed;

    logic [11:0] wr_addr_q[$];
    logic [7:0]  wr_data_q[$];
    int          busy_cnt;
    int          ovf_cnt;

    term_char_writer dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .key_data   (key_data),
        .new_key    (new_key),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .top_row    (top_row),
        .busy       (busy),
        .overflow   (overflow)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Log RAM writes and count busy/overflow cycles, sampled mid-cycle.
    always @(negedge sys_clk) begin
        if (ram_we) begin
            wr_addr_q.push_back(ram_addr);
            wr_data_q.push_back(ram_wdata);
        end
        if (busy)
            busy_cnt = busy_cnt + 1;
        if (overflow)
            ovf_cnt = ovf_cnt + 1;
    end

    task automatic send_key(input logic [7:0] ch);
        @(negedge sys_clk);
        key_data = ch;
        new_key  = 1'b1;
        repeat (3) @(negedge sys_clk);
        new_key = 1'b0;
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic test_reset;
        rst      = 1'b1;
        new_key  = 1'b1;
        key_data = 8'h55;
        repeat (3) @(negedge sys_clk);
        tests_run++;
        if ({ram_we, ram_addr, ram_wdata, cursor_col, cursor_row, top_row, busy, overflow} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: we=%0b addr=%0d wdata=%h col=%0d row=%0d top=%0d busy=%0b ovf=%0b, required all zero",
                     ram_we, ram_addr, ram_wdata, cursor_col, cursor_row, top_row, busy, overflow);
        end
        rst = 1'b0;
        repeat (8) @(negedge sys_clk);
        tests_run++;
        if (wr_addr_q.size() != 0 || ovf_cnt != 0) begin
            tests_failed++;
            $display("FAIL reset_held_key: writes=%0d overflows=%0d, required 0 and 0", wr_addr_q.size(), ovf_cnt);
        end
        new_key = 1'b0;
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic test_first_char;
        logic seen_early;
        seen_early = 1'b0;
        @(negedge sys_clk);
        key_data = 8'h41;
        new_key  = 1'b1;
        repeat (3) begin
            @(negedge sys_clk);
            if (ram_we) seen_early = 1'b1;
        end
        tests_run++;
        if (seen_early) begin
            tests_failed++;
            $display("FAIL first_char_early: ram_we seen before 3rd edge, required low");
        end
        @(negedge sys_clk);
        tests_run++;
        if (ram_we !== 1'b1 || ram_addr !== 12'd0 || ram_wdata !== 8'h41) begin
            tests_failed++;
            $display("FAIL first_char_write: we=%0b addr=%0d data=%h, required 1/0/41", ram_we, ram_addr, ram_wdata);
        end
        new_key = 1'b0;
        repeat (4) @(negedge sys_clk);
        tests_run++;
        if (cursor_col !== 7'd1 || wr_addr_q.size() != 1) begin
            tests_failed++;
            $display("FAIL first_char_cursor: col=%0d writes=%0d, required 1 and 1", cursor_col, wr_addr_q.size());
        end
    endtask

    task automatic test_line_wrap;
        int base;
        int bbase;
        logic ok;
        send_key(8'h0D);
        base  = wr_addr_q.size();
        bbase = busy_cnt;
        tests_run++;
        if (cursor_col !== 7'd0 || base != 1) begin
            tests_failed++;
            $display("FAIL cr: col=%0d writes=%0d, required 0 and 1", cursor_col, base);
        end
        for (int i = 0; i < 80; i++) send_key(8'h78);
        send_key(8'h79);
        repeat (3) @(negedge sys_clk);
        ok = (wr_addr_q.size() == base + 81);
        for (int i = 0; i < 80 && ok; i++)
            if (wr_addr_q[base + i] !== 12'(i) || wr_data_q[base + i] !== 8'h78) ok = 1'b0;
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL wrap_x_row: writes=%0d, required 81 with x at 0..79", wr_addr_q.size() - base);
        end
        tests_run++;
        if (!ok || wr_addr_q[base + 80] !== 12'd80 || wr_data_q[base + 80] !== 8'h79) begin
            tests_failed++;
            $display("FAIL wrap_y: y write missing or misplaced, required addr 80 data 79");
        end
        tests_run++;
        if (cursor_col !== 7'd1 || cursor_row !== 5'd1 || busy_cnt != bbase) begin
            tests_failed++;
            $display("FAIL wrap_cursor: col=%0d row=%0d busy_cycles=%0d, required 1/1/0", cursor_col, cursor_row, busy_cnt - bbase);
        end
    endtask

    task automatic test_scroll;
        int base;
        int bbase;
        logic ok;
        send_key(8'h0D);
        for (int i = 0; i < 28; i++) send_key(8'h0A);
        base = wr_addr_q.size();
        for (int i = 0; i < 5; i++) send_key(8'h71);
        ok = (wr_addr_q.size() == base + 5);
        for (int i = 0; i < 5 && ok; i++)
            if (wr_addr_q[base + i] !== 12'(2320 + i)) ok = 1'b0;
        tests_run++;
        if (!ok || cursor_row !== 5'd29 || cursor_col !== 7'd5) begin
            tests_failed++;
            $display("FAIL scroll_setup: row=%0d col=%0d writes=%0d, required 29/5/5 at 2320..", cursor_row, cursor_col, wr_addr_q.size() - base);
        end
        base  = wr_addr_q.size();
        bbase = busy_cnt;
        send_key(8'h0A);
        repeat (90) @(negedge sys_clk);
        tests_run++;
        if (top_row !== 5'd1 || cursor_row !== 5'd29 || cursor_col !== 7'd5) begin
            tests_failed++;
            $display("FAIL scroll_cursor: top=%0d row=%0d col=%0d, required 1/29/5", top_row, cursor_row, cursor_col);
        end
        tests_run++;
        if (busy_cnt - bbase != 80) begin
            tests_failed++;
            $display("FAIL scroll_busy: busy_cycles=%0d, required 80", busy_cnt - bbase);
        end
        ok = (wr_addr_q.size() == base + 80);
        for (int i = 0; i < 80 && ok; i++)
            if (wr_addr_q[base + i] !== 12'(i) || wr_data_q[base + i] !== 8'h20) ok = 1'b0;
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL scroll_clear: writes=%0d, required 80 spaces at 0..79", wr_addr_q.size() - base);
        end
    endtask

    task automatic test_backspace;
        int base;
        send_key(8'h0D);
        base = wr_addr_q.size();
        send_key(8'h08);
        repeat (2) @(negedge sys_clk);
        tests_run++;
        if (wr_addr_q.size() != base || cursor_col !== 7'd0) begin
            tests_failed++;
            $display("FAIL bs_col0: writes=%0d col=%0d, required 0 and 0", wr_addr_q.size() - base, cursor_col);
        end
        for (int i = 0; i < 3; i++) send_key(8'h6D);
        base = wr_addr_q.size();
        send_key(8'h08);
        repeat (2) @(negedge sys_clk);
        tests_run++;
        if (wr_addr_q.size() != base + 1 || wr_addr_q[base] !== 12'd2 || wr_data_q[base] !== 8'h20 || cursor_col !== 7'd2) begin
            tests_failed++;
            $display("FAIL bs_col3: writes=%0d col=%0d, required one space at addr 2, col 2", wr_addr_q.size() - base, cursor_col);
        end
    endtask

    task automatic test_ff_overflow;
        int base;
        int obase;
        logic ok;
        logic done;
        base  = wr_addr_q.size();
        obase = ovf_cnt;
        send_key(8'h0C);
        send_key(8'h61);
        send_key(8'h62);
        send_key(8'h63);
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge sys_clk);
            if (!busy) done = 1'b1;
        end
        tests_run++;
        if (!done) begin
            tests_failed++;
            $display("FAIL ff_timeout: busy still %0b after 3000 cycles, required 0", busy);
        end
        repeat (10) @(negedge sys_clk);
        tests_run++;
        if (ovf_cnt - obase != 2) begin
            tests_failed++;
            $display("FAIL ff_overflow: pulses=%0d, required 2", ovf_cnt - obase);
        end
        ok = (wr_addr_q.size() == base + 2401);
        for (int i = 0; i < 2400 && ok; i++)
            if (wr_addr_q[base + i] !== 12'(i) || wr_data_q[base + i] !== 8'h20) ok = 1'b0;
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL ff_clear: writes=%0d, required 2400 spaces in order plus one char", wr_addr_q.size() - base);
        end
        tests_run++;
        if (!ok || wr_addr_q[base + 2400] !== 12'd0 || wr_data_q[base + 2400] !== 8'h61 ||
            cursor_col !== 7'd1 || cursor_row !== 5'd0 || top_row !== 5'd0) begin
            tests_failed++;
            $display("FAIL ff_held_char: col=%0d row=%0d top=%0d, required a at addr 0 and cursor 1/0/0", cursor_col, cursor_row, top_row);
        end
    endtask

    task automatic test_reset_mid_clear;
        int base;
        send_key(8'h0C);
        repeat (50) @(negedge sys_clk);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL midclr_busy: busy=%0b, required 1", busy);
        end
        @(posedge sys_clk);
        #2 rst = 1'b1;
        @(negedge sys_clk);
        tests_run++;
        if ({ram_we, ram_addr, ram_wdata, cursor_col, cursor_row, top_row, busy, overflow} !== '0) begin
            tests_failed++;
            $display("FAIL midclr_reset: we=%0b addr=%0d wdata=%h col=%0d row=%0d top=%0d busy=%0b ovf=%0b, required all zero",
                     ram_we, ram_addr, ram_wdata, cursor_col, cursor_row, top_row, busy, overflow);
        end
        base = wr_addr_q.size();
        rst = 1'b0;
        repeat (20) @(negedge sys_clk);
        tests_run++;
        if (wr_addr_q.size() != base || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL midclr_abort: writes=%0d busy=%0b, required 0 and 0", wr_addr_q.size() - base, busy);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        busy_cnt     = 0;
        ovf_cnt      = 0;
        rst          = 1'b1;
        new_key      = 1'b0;
        key_data     = 8'h00;
        test_reset();
        test_first_char();
        test_line_wrap();
        test_scroll();
        test_backspace();
        test_ff_overflow();
        test_reset_mid_clear();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
